// File: rtl/muldiv_sequencer.sv
// Iterative 32-step shift-add multiplier / restoring divider feeding the HI/LO
// write path; stalls the pipeline until the signed-corrected result is strobed.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             HiLoWrite,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic             r_sa, r_sb, r_bz;
  logic [WIDTH-1:0] r_m;   // multiplicand or divisor
  logic [WIDTH-1:0] r_hi;  // accumulator high / remainder
  logic [WIDTH-1:0] r_lo;  // multiplier, then product low / quotient

  logic             w_sgn, w_neg_a, w_neg_b, w_bz;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH:0]   w_sum, w_rsh;
  logic [WIDTH-1:0] w_rdiff;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod, w_prod_neg;
  logic [WIDTH-1:0] w_q_neg, w_r_neg;

  assign w_sgn   = ~Op[0];
  assign w_neg_a = w_sgn & A[WIDTH-1];
  assign w_neg_b = w_sgn & B[WIDTH-1];
  assign w_abs_a = w_neg_a ? (~A + 1'b1) : A;
  assign w_abs_b = w_neg_b ? (~B + 1'b1) : B;
  assign w_bz    = Op[1] & (B == '0);

  assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : '0)};
  assign w_rsh   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = w_rsh >= {1'b0, r_m};
  // Remainder after subtraction is always below the divisor, so WIDTH bits suffice.
  assign w_rdiff = w_rsh[WIDTH-1:0] - r_m;

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_neg = ~w_prod + 1'b1;
  assign w_q_neg    = ~r_lo + 1'b1;
  assign w_r_neg    = ~r_hi + 1'b1;

  assign Busy      = (r_state == S_RUN) || (r_state == S_FIX);
  assign Stall     = (r_state != S_IDLE);
  assign Done      = (r_state == S_DONE);
  assign HiLoWrite = Done & ~Cancel;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_bz      <= 1'b0;
      r_m       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      HiOut     <= '0;
      LoOut     <= '0;
      DivByZero <= 1'b0;
    end else if (Cancel && r_state != S_IDLE) begin
      r_state   <= S_IDLE;
      DivByZero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (Start && !Cancel) begin
          r_op  <= Op;
          r_sa  <= w_neg_a;
          r_sb  <= w_neg_b;
          r_bz  <= w_bz;
          r_cnt <= '0;
          r_hi  <= '0;
          if (w_bz) begin
            r_m     <= '0;
            r_lo    <= A;
            r_state <= S_FIX;
          end else begin
            r_m     <= Op[1] ? w_abs_b : w_abs_a;
            r_lo    <= Op[1] ? w_abs_a : w_abs_b;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[1]) begin
            r_hi <= w_ge ? w_rdiff : w_rsh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else begin
            {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
          end
          if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_bz) begin
            HiOut     <= r_lo;
            LoOut     <= '1;
            DivByZero <= 1'b1;
          end else if (!r_op[1]) begin
            {HiOut, LoOut} <= (~r_op[0] & (r_sa ^ r_sb)) ? w_prod_neg : w_prod;
          end else begin
            LoOut <= (~r_op[0] & (r_sa ^ r_sb)) ? w_q_neg : r_lo;
            HiOut <= (~r_op[0] & r_sa) ? w_r_neg : r_hi;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          DivByZero <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random bench for muldiv_sequencer against a plain-arithmetic
// model of mult/multu/div/divu, including cancel, reset and divide-by-zero.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         Clk = 1'b0, Rst = 1'b0, Start = 1'b0, Cancel = 1'b0;
  logic [1:0]   Op = '0;
  logic [W-1:0] A = '0, B = '0;
  logic         Busy, Stall, Done, HiLoWrite, DivByZero;
  logic [W-1:0] HiOut, LoOut;

  int n_tests = 0, n_fail = 0;
  logic [63:0] prev = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Cancel(Cancel),
    .Busy(Busy), .Stall(Stall), .Done(Done), .HiLoWrite(HiLoWrite),
    .HiOut(HiOut), .LoOut(LoOut), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {dbz, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          q, rm;
    longint unsigned uq, urm;
    logic [63:0]     r;
    case (op)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        q = sa / sb; rm = sa % sb;
        r = {rm[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        uq = ua / ub; urm = ua % ub;
        r = {urm[31:0], uq[31:0]};
      end
    endcase
    return {1'b0, r};
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom; Op = 2'($urandom);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] m;
    int L;
    m = model(op, a, b);
    L = m[64] ? 1 : W + 1;
    issue(op, a, b);
    for (int k = 0; k <= L; k++) begin
      chk("status", {Busy, Stall, Done, HiLoWrite, DivByZero},
          {k < L, 1'b1, k == L, k == L, (k == L) && m[64]});
      if (k == L) chk("result", {HiOut, LoOut}, m[63:0]);
      @(posedge Clk); #1;
    end
    chk("idle_after", {Busy, Stall, Done, HiLoWrite, DivByZero}, 0);
    prev = m[63:0];
  endtask

  task automatic cancel_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int ck);
    logic [64:0] m;
    int L, wr;
    m = model(op, a, b);
    L = m[64] ? 1 : W + 1;
    issue(op, a, b);
    for (int k = 0; k < ck; k++) begin
      @(posedge Clk); #1;
    end
    Cancel = 1'b1; #1;
    chk("cancel_same_cycle", {Busy, Stall, Done, HiLoWrite}, {ck < L, 1'b1, ck == L, 1'b0});
    @(posedge Clk); #1;
    Cancel = 1'b0;
    chk("cancel_idle", {Busy, Stall, Done, HiLoWrite, DivByZero}, 0);
    if (ck >= L) prev = m[63:0];
    chk("cancel_hold", {HiOut, LoOut}, prev);
    wr = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge Clk); #1;
      if (HiLoWrite || Stall) wr++;
    end
    chk("cancel_no_write", 64'(wr), 0);
  endtask

  initial begin
    #12;
    chk("reset_outs", {Busy, Stall, Done, HiLoWrite, DivByZero}, 0);
    chk("reset_hilo", {HiOut, LoOut}, 0);
    @(negedge Clk); Rst = 1'b1;

    do_op(2'd1, 32'd7, 32'd6);
    do_op(2'd0, 32'hFFFFFFFD, 32'd5);
    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(2'd2, 32'hFFFFFFF9, 32'd2);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    do_op(2'd3, 32'h12345678, 32'd0);
    do_op(2'd0, 32'h80000000, 32'h80000000);
    do_op(2'd2, 32'h80000001, 32'd0);
    do_op(2'd2, 32'd7, 32'hFFFFFFFE);

    cancel_op(2'd1, 32'd1234, 32'd5678, 10);
    cancel_op(2'd2, 32'hFFFF0000, 32'd3, W);
    cancel_op(2'd0, 32'hFFFFFFFF, 32'd9, W + 1);
    cancel_op(2'd3, 32'h0BADF00D, 32'd0, 1);

    // Start together with Cancel in IDLE must not launch
    @(negedge Clk); Start = 1'b1; Cancel = 1'b1; Op = 2'd1; A = 32'd5; B = 32'd5;
    @(posedge Clk); #1; Start = 1'b0; Cancel = 1'b0;
    chk("start_cancel_idle", {Busy, Stall, Done}, 0);
    @(posedge Clk); #1;
    chk("start_cancel_idle2", {Busy, Stall, Done, HiLoWrite}, 0);

    // asynchronous reset between edges in cycle 15
    issue(2'd0, 32'h00ABCDEF, 32'hFFFFF000);
    for (int k = 0; k < 15; k++) begin
      @(posedge Clk); #1;
    end
    #2; Rst = 1'b0; #1;
    chk("midrun_reset_outs", {Busy, Stall, Done, HiLoWrite, DivByZero}, 0);
    chk("midrun_reset_hilo", {HiOut, LoOut}, 0);
    @(negedge Clk); Rst = 1'b1;
    do_op(2'd1, 32'd3, 32'd3);

    for (int i = 0; i < 16; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      do_op(op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
